// File: rtl/pid_wall_controller.sv
// pid_wall_controller: one PID update per accepted distance sample, shared multiplier.
// Latency: out_valid is registered on the 5th clock edge after the edge that accepts sample_valid.
// Backpressure: none; sample_valid arriving while busy (including the SUM cycle) is dropped.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   enable            run control; low aborts any update, clears history, forces out to 0
//   sample_valid      one-cycle strobe qualifying sample/setpoint/kp/ki/kd
//   sample, setpoint  signed 16-bit measurement and target
//   kp, ki, kd        unsigned gains with FRAC fractional bits
//   out, out_valid    signed saturated command and its one-cycle update strobe
//   busy              high while an update is in flight
//
// Optional feature macro: PID_ANTI_WINDUP_EN (conditional integration while output is saturated).
module pid_wall_controller #(
  parameter int FRAC    = 8,
  parameter int I_LIMIT = 1048576,
  parameter int OUT_MAX = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [15:0] sample,
  input  logic [15:0] setpoint,
  input  logic [15:0] kp,
  input  logic [15:0] ki,
  input  logic [15:0] kd,
  output logic [15:0] out,
  output logic        out_valid,
  output logic        busy
);

  localparam int AW = 52;  // accumulator width for P + I + D
  localparam int IW = 32;  // integrator width
  localparam int MW = 49;  // multiplier operand/product width (17-bit gain x 32-bit data)

  localparam logic signed [IW-1:0] ILIM   = IW'(I_LIMIT);
  localparam logic signed [AW-1:0] SMAX   = AW'(OUT_MAX);
  localparam logic        [15:0]   OMAX16 = 16'(OUT_MAX);
  localparam logic        [15:0]   OMIN16 = 16'(-OUT_MAX);

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    PMUL,
    IMUL,
    DMUL,
    SUM
  } state_t;

  state_t                 state;
  logic signed [15:0]     smp_r;
  logic signed [15:0]     sp_r;
  logic        [15:0]     kp_r;
  logic        [15:0]     ki_r;
  logic        [15:0]     kd_r;
  logic signed [16:0]     err;
  logic signed [17:0]     d_in;
  logic signed [IW-1:0]   integ;
  logic signed [16:0]     prev_err;
  logic                   first;
  logic signed [AW-1:0]   acc;

  // Error, derivative input and next integrator value, all from the latched sample.
  logic signed [16:0]     err_c;
  logic signed [17:0]     d_c;
  logic signed [IW-1:0]   integ_sum;
  logic signed [IW-1:0]   integ_c;
  logic                   hold_integ;

  assign err_c     = {sp_r[15], sp_r} - {smp_r[15], smp_r};
  assign d_c       = first ? 18'sd0 : ({err_c[16], err_c} - {prev_err[16], prev_err});
  assign integ_sum = integ + {{(IW-17){err_c[16]}}, err_c};

  always_comb begin
    integ_c = integ_sum;
    if (integ_sum > ILIM) begin
      integ_c = ILIM;
    end else if (integ_sum < -ILIM) begin
      integ_c = -ILIM;
    end
  end

`ifdef PID_ANTI_WINDUP_EN
  // Stop integrating further into a rail the output is already pinned against.
  assign hold_integ = ((out == OMAX16) && !err_c[16] && (err_c != 17'sd0)) ||
                      ((out == OMIN16) && err_c[16]);
`else
  assign hold_integ = 1'b0;
`endif

  // Shared multiplier: gain is zero-extended, data operand is sign-extended.
  logic signed [MW-1:0] mul_a;
  logic signed [MW-1:0] mul_b;
  logic signed [MW-1:0] prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] term;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      PMUL: begin
        mul_a = {{(MW-16){1'b0}}, kp_r};
        mul_b = {{(MW-17){err[16]}}, err};
      end
      IMUL: begin
        mul_a = {{(MW-16){1'b0}}, ki_r};
        mul_b = {{(MW-IW){integ[IW-1]}}, integ};
      end
      DMUL: begin
        mul_a = {{(MW-16){1'b0}}, kd_r};
        mul_b = {{(MW-18){d_in[17]}}, d_in};
      end
      default: ;
    endcase
  end

  // Product magnitude stays below 2^47, so the 49-bit signed product is exact.
  assign prod     = mul_a * mul_b;
  assign prod_ext = {{(AW-MW){prod[MW-1]}}, prod};
  assign term     = prod_ext >>> FRAC;

  logic [15:0] sat_c;

  always_comb begin
    sat_c = acc[15:0];
    if (acc > SMAX) begin
      sat_c = OMAX16;
    end else if (acc < -SMAX) begin
      sat_c = OMIN16;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      smp_r     <= '0;
      sp_r      <= '0;
      kp_r      <= '0;
      ki_r      <= '0;
      kd_r      <= '0;
      err       <= '0;
      d_in      <= '0;
      integ     <= '0;
      prev_err  <= '0;
      first     <= 1'b1;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (!enable) begin
      // Abort takes priority over every state, including a completing SUM.
      state     <= IDLE;
      integ     <= '0;
      prev_err  <= '0;
      first     <= 1'b1;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            smp_r <= sample;
            sp_r  <= setpoint;
            kp_r  <= kp;
            ki_r  <= ki;
            kd_r  <= kd;
            busy  <= 1'b1;
            state <= ERR;
          end
        end
        ERR: begin
          err  <= err_c;
          d_in <= d_c;
          if (!hold_integ) begin
            integ <= integ_c;
          end
          state <= PMUL;
        end
        PMUL: begin
          acc   <= term;
          state <= IMUL;
        end
        IMUL: begin
          acc   <= acc + term;
          state <= DMUL;
        end
        DMUL: begin
          acc   <= acc + term;
          state <= SUM;
        end
        SUM: begin
          out       <= sat_c;
          out_valid <= 1'b1;
          prev_err  <= err;
          first     <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_wall_controller.sv
module tb_pid_wall_controller;

  localparam int FRAC    = 8;
  localparam int I_LIMIT = 1048576;
  localparam int OUT_MAX = 1000;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               sample_valid;
  logic        [15:0] sample;
  logic        [15:0] setpoint;
  logic        [15:0] kp;
  logic        [15:0] ki;
  logic        [15:0] kd;
  logic signed [15:0] out;
  logic               out_valid;
  logic               busy;

  always #5 clk = ~clk;

  pid_wall_controller #(
    .FRAC   (FRAC),
    .I_LIMIT(I_LIMIT),
    .OUT_MAX(OUT_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sample_valid(sample_valid),
    .sample      (sample),
    .setpoint    (setpoint),
    .kp          (kp),
    .ki          (ki),
    .kd          (kd),
    .out         (out),
    .out_valid   (out_valid),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected output: the edge count at which out_valid must be seen, and its value.
  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model of the controller's history.
  int m_integ;
  int m_prev;
  int m_last;
  bit m_first;
  int free_edge;

  function automatic void model_clear();
    m_integ = 0;
    m_prev  = 0;
    m_last  = 0;
    m_first = 1'b1;
  endfunction

  function automatic int model_update(input int err, input int kpv, input int kiv, input int kdv);
    int     d;
    bit     hold;
    longint p;
    longint i;
    longint dd;
    longint s;
    d    = m_first ? 0 : err - m_prev;
    hold = 1'b0;
`ifdef PID_ANTI_WINDUP_EN
    hold = (m_last == OUT_MAX && err > 0) || (m_last == -OUT_MAX && err < 0);
`endif
    if (!hold) begin
      m_integ = m_integ + err;
      if (m_integ > I_LIMIT) m_integ = I_LIMIT;
      if (m_integ < -I_LIMIT) m_integ = -I_LIMIT;
    end
    p  = (longint'(kpv) * longint'(err)) >>> FRAC;
    i  = (longint'(kiv) * longint'(m_integ)) >>> FRAC;
    dd = (longint'(kdv) * longint'(d)) >>> FRAC;
    s  = p + i + dd;
    if (s > OUT_MAX) s = OUT_MAX;
    if (s < -OUT_MAX) s = -OUT_MAX;
    m_prev  = err;
    m_first = 1'b0;
    m_last  = int'(s);
    return int'(s);
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes out_valid.
  always @(negedge clk) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_out_valid: out_valid absent, required one at cycle %0d (now %0d)", sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got out_valid with out=%0d at cycle %0d, required none", out, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("out_valid_cycle", cyc, mon_e.due);
          check("out_value", out, mon_e.val);
        end
      end
    end
  end

  // Drive one cycle of inputs right after a rising edge; they are sampled at edge cyc+1.
  task automatic step(input bit en, input bit sv, input int sp, input int smp,
                      input int kpv, input int kiv, input int kdv);
    int   e;
    exp_t x;
    enable       = en;
    sample_valid = sv;
    setpoint     = 16'(sp);
    sample       = 16'(smp);
    kp           = 16'(kpv);
    ki           = 16'(kiv);
    kd           = 16'(kdv);
    e = cyc + 1;
    if (!en) begin
      while (sb.size() > 0 && sb[$].due >= e) void'(sb.pop_back());
      model_clear();
      free_edge = e + 1;
    end else if (sv && e >= free_edge) begin
      x.due = e + 5;
      x.val = model_update(sp - smp, kpv, kiv, kdv);
      sb.push_back(x);
      free_edge = e + 6;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) begin
      step(en, 1'b0, int'($signed(setpoint)), int'($signed(sample)), int'(kp), int'(ki), int'(kd));
    end
  endtask

  task automatic samp(input int sp, input int smp, input int kpv, input int kiv, input int kdv);
    step(1'b1, 1'b1, sp, smp, kpv, kiv, kdv);
    idle(6, 1'b1);
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;
    setpoint     = '0;
    kp           = '0;
    ki           = '0;
    kd           = '0;
    model_clear();
    free_edge = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    idle(2, 1'b1);

    // Proportional only, with busy framing the update.
    check("busy_idle", busy, 0);
    step(1'b1, 1'b1, 1000, 600, 16'h0100, 0, 0);
    check("busy_set", busy, 1);
    idle(6, 1'b1);
    check("busy_clear", busy, 0);

    // Enable low forces out to zero.
    idle(1, 1'b0);
    check("out_forced_zero", out, 0);
    check("out_valid_low_disabled", out_valid, 0);

    // Saturation in both directions.
    samp(1000, 600, 16'h0A00, 0, 0);
    samp(1000, 1400, 16'h0A00, 0, 0);

    // Integrator accumulation, then history cleared by an enable drop.
    idle(1, 1'b0);
    for (int i = 0; i < 3; i++) samp(1010, 1000, 0, 16'h0100, 0);
    idle(1, 1'b0);
    samp(1010, 1000, 0, 16'h0100, 0);

    // Derivative with first-sample suppression.
    idle(1, 1'b0);
    samp(100, 0, 0, 0, 16'h0200);
    samp(150, 0, 0, 0, 16'h0200);

    // Second strobe while busy is dropped; follow-up shows one integration only.
    idle(1, 1'b0);
    step(1'b1, 1'b1, 1010, 1000, 0, 16'h0100, 0);
    idle(1, 1'b1);
    step(1'b1, 1'b1, 1010, 1000, 0, 16'h0100, 0);
    idle(6, 1'b1);
    samp(1010, 1000, 0, 16'h0100, 0);

    // Strobe landing on the SUM cycle is dropped; the next cycle is accepted.
    step(1'b1, 1'b1, 1020, 1000, 0, 16'h0100, 0);
    idle(4, 1'b1);
    step(1'b1, 1'b1, 1500, 1000, 0, 16'h0100, 0);
    step(1'b1, 1'b1, 1030, 1000, 0, 16'h0100, 0);
    idle(6, 1'b1);

    // Windup: integrator contents revealed afterwards with a small ki and zero error.
    idle(1, 1'b0);
    for (int i = 0; i < 4; i++) samp(1400, 1000, 16'h0A00, 16'h0100, 0);
    samp(1000, 1000, 0, 16'h0040, 0);

    // Reset in the middle of an update: no out_valid may follow.
    step(1'b1, 1'b1, 1400, 1000, 16'h0A00, 16'h0100, 0);
    idle(2, 1'b1);
    reset = 1'b1;
    sb.delete();
    model_clear();
    free_edge = 0;
    #2;
    check("midreset_out", out, 0);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(10, 1'b1);

    // Randomized traffic: random timing, drops, enable pulses, gains and operands.
    for (int c = 0; c < 2000; c++) begin
      bit en;
      bit sv;
      int sp;
      int smp;
      int kpv;
      int kiv;
      int kdv;
      en = ($urandom_range(0, 59) != 0);
      sv = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin
        sp  = int'($urandom_range(0, 1200)) - 600;
        smp = int'($urandom_range(0, 1200)) - 600;
        kpv = int'($urandom_range(0, 768));
        kiv = int'($urandom_range(0, 64));
        kdv = int'($urandom_range(0, 768));
      end else begin
        sp  = int'($urandom_range(0, 65535)) - 32768;
        smp = int'($urandom_range(0, 65535)) - 32768;
        kpv = int'($urandom_range(0, 65535));
        kiv = int'($urandom_range(0, 65535));
        kdv = int'($urandom_range(0, 65535));
      end
      step(en, sv, sp, smp, kpv, kiv, kdv);
    end

    idle(10, 1'b1);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
